attention_seq_ctrl: RTL

Sequencer for the binary attention datapath. It steps the five attention stages in order (QKV projection, attention score, weighted value, intermediate 1, intermediate 2) over a 30-time-step sequence. For each stage it issues one indexed valid beat per time step and waits for the stage's done pulse before advancing. It repeats the stage sequence for each encoder block, driving `block_sel`, and sits between the top-level host/FSM and the attention datapath stage enables.

---
 rtl/attention_seq_ctrl_if.sv | 60 ++++++
 rtl/attention_seq_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/attention_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// attention_seq_ctrl_if
//
// Handshake bundle between the attention sequencer, the host that launches a
// run, and the attention datapath whose stage enables it drives.
//
// Signals:
//   start       host -> seq   level request, acted on only while idle
//   stall       dp   -> seq   backpressure, suppresses the current beat
//   stage_done  dp   -> seq   one-cycle pulse, active stage has finished
//   stage_id    seq  -> dp    active stage, 0..NUM_STAGES-1
//   block_sel   seq  -> dp    active encoder block, 0..NUM_BLOCKS-1
//   step_idx    seq  -> dp    time-step row of the current beat
//   step_valid  seq  -> dp    beat strobe, row step_idx is written when high
//   busy        seq  -> host  high whenever a run is in progress
//   done        seq  -> host  one-cycle pulse at the end of a run
//   err         seq  -> host  sticky watchdog flag
//
// Modports:
//   master  the sequencer itself
//   slave   the host/datapath side
// -----------------------------------------------------------------------------
interface attention_seq_ctrl_if;
    logic       start;
    logic       stall;
    logic       stage_done;
    logic [2:0] stage_id;
    logic [2:0] block_sel;
    logic [4:0] step_idx;
    logic       step_valid;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        input  start,
        input  stall,
        input  stage_done,
        output stage_id,
        output block_sel,
        output step_idx,
        output step_valid,
        output busy,
        output done,
        output err
    );

    modport slave (
        output start,
        output stall,
        output stage_done,
        input  stage_id,
        input  block_sel,
        input  step_idx,
        input  step_valid,
        input  busy,
        input  done,
        input  err
    );
endinterface

// File: rtl/attention_seq_ctrl.sv
// -----------------------------------------------------------------------------
// attention_seq_ctrl
//
// Sequencer for the binary attention datapath. For every encoder block it walks
// the five attention stages in order; inside a stage it issues one indexed beat
// per time step, then waits for the stage's done pulse before moving on. After
// the last stage of the last block it pulses done and returns to idle.
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   bus     attention_seq_ctrl_if.master
//             in : start, stall, stage_done
//             out: stage_id, block_sel, step_idx, step_valid, busy, done, err
//
// Parameters:
//   STEPS       time steps per stage (1..32)
//   NUM_STAGES  stages per block (1..8)
//   NUM_BLOCKS  encoder blocks per run (1..8)
//   TIMEOUT     watchdog limit in WAIT cycles (1..1023)
//
// Build option:
//   ATTN_SEQ_TIMEOUT_EN  when defined, a watchdog abandons a run whose stage
//                        never reports done within TIMEOUT cycles and raises a
//                        sticky err. When undefined, no watchdog is built and
//                        err is constant 0.
// -----------------------------------------------------------------------------
module attention_seq_ctrl #(
    parameter int STEPS      = 30,
    parameter int NUM_STAGES = 5,
    parameter int NUM_BLOCKS = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic                        clk,
    input  logic                        rst_n,
    attention_seq_ctrl_if.master        bus
);

    // Elaboration-time range checks on the configuration.
    if (STEPS < 1 || STEPS > 32) begin : g_bad_steps
        $error("attention_seq_ctrl: STEPS must be 1..32");
    end
    if (NUM_STAGES < 1 || NUM_STAGES > 8) begin : g_bad_stages
        $error("attention_seq_ctrl: NUM_STAGES must be 1..8");
    end
    if (NUM_BLOCKS < 1 || NUM_BLOCKS > 8) begin : g_bad_blocks
        $error("attention_seq_ctrl: NUM_BLOCKS must be 1..8");
    end
    if (TIMEOUT < 1 || TIMEOUT > 1023) begin : g_bad_timeout
        $error("attention_seq_ctrl: TIMEOUT must be 1..1023");
    end

    localparam logic [4:0] LP_LAST_STEP  = 5'(STEPS - 1);
    localparam logic [2:0] LP_LAST_STAGE = 3'(NUM_STAGES - 1);
    localparam logic [2:0] LP_LAST_BLOCK = 3'(NUM_BLOCKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t     r_state,     w_state_next;
    logic [2:0] r_stage_id,  w_stage_id_next;
    logic [2:0] r_block_sel, w_block_sel_next;
    logic [4:0] r_step_idx,  w_step_idx_next;
    logic       r_busy,      w_busy_next;
    logic       r_done,      w_done_next;

    // start is registered before the FSM looks at it, which gives the
    // one-cycle launch latency between seeing start and the first beat.
    logic       r_start_q;

    logic       w_step_valid;

`ifdef ATTN_SEQ_TIMEOUT_EN
    localparam logic [9:0] LP_WDOG_LAST = 10'(TIMEOUT - 1);

    logic       r_err, w_err_next;
    logic [9:0] r_wdog_cnt;
    logic       w_wdog_expired;

    // Counter reads 0 on the first WAIT cycle, so the TIMEOUT-th WAIT cycle
    // without stage_done is the one that sees LP_WDOG_LAST.
    assign w_wdog_expired = (r_wdog_cnt >= LP_WDOG_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog_cnt <= '0;
        end else if (r_state != ST_WAIT) begin
            r_wdog_cnt <= '0;
        end else if (!w_wdog_expired) begin
            r_wdog_cnt <= r_wdog_cnt + 10'd1;
        end
    end
`endif

    // The beat strobe is the registered ISSUE state gated by the live stall,
    // so a stalled cycle drops the beat without a cycle of skid.
    assign w_step_valid = (r_state == ST_ISSUE) && !bus.stall;

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        w_stage_id_next  = r_stage_id;
        w_block_sel_next = r_block_sel;
        w_step_idx_next  = r_step_idx;
`ifdef ATTN_SEQ_TIMEOUT_EN
        w_err_next       = r_err;
`endif

        case (r_state)
            ST_IDLE: begin
                if (r_start_q) begin
                    w_state_next     = ST_ISSUE;
                    w_stage_id_next  = '0;
                    w_block_sel_next = '0;
                    w_step_idx_next  = '0;
`ifdef ATTN_SEQ_TIMEOUT_EN
                    w_err_next       = 1'b0;
`endif
                end
            end

            ST_ISSUE: begin
                if (w_step_valid) begin
                    if (r_step_idx < LP_LAST_STEP) begin
                        w_step_idx_next = r_step_idx + 5'd1;
                    end else begin
                        // Last row issued: index stays on the final step.
                        w_state_next = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                if (bus.stage_done) begin
                    if (r_stage_id < LP_LAST_STAGE) begin
                        w_stage_id_next = r_stage_id + 3'd1;
                        w_step_idx_next = '0;
                        w_state_next    = ST_ISSUE;
                    end else if (r_block_sel < LP_LAST_BLOCK) begin
                        w_block_sel_next = r_block_sel + 3'd1;
                        w_stage_id_next  = '0;
                        w_step_idx_next  = '0;
                        w_state_next     = ST_ISSUE;
                    end else begin
                        w_state_next = ST_DONE;
                    end
                end
`ifdef ATTN_SEQ_TIMEOUT_EN
                else if (w_wdog_expired) begin
                    // Abandon the run; DONE supplies the done pulse.
                    w_err_next   = 1'b1;
                    w_state_next = ST_DONE;
                end
`endif
            end

            ST_DONE: begin
                w_state_next     = ST_IDLE;
                w_stage_id_next  = '0;
                w_block_sel_next = '0;
                w_step_idx_next  = '0;
            end

            default: begin
                w_state_next     = ST_IDLE;
                w_stage_id_next  = '0;
                w_block_sel_next = '0;
                w_step_idx_next  = '0;
            end
        endcase

        // busy and done are registered images of the state being entered.
        w_busy_next = (w_state_next != ST_IDLE);
        w_done_next = (w_state_next == ST_DONE);
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_start_q   <= 1'b0;
            r_stage_id  <= '0;
            r_block_sel <= '0;
            r_step_idx  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_start_q   <= bus.start;
            r_stage_id  <= w_stage_id_next;
            r_block_sel <= w_block_sel_next;
            r_step_idx  <= w_step_idx_next;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
        end
    end

`ifdef ATTN_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_next;
        end
    end

    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.stage_id   = r_stage_id;
    assign bus.block_sel  = r_block_sel;
    assign bus.step_idx   = r_step_idx;
    assign bus.step_valid = w_step_valid;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

endmodule
